ysyx_23060201_lsu: RTL and testbench

Load/store unit: the initiator side of the core's data-memory port. Accepts one load or store per transaction from EXU over valid/ready, drives the memory strobe/address/mask/data port and captures read data. Extracts and extends load data, then returns the result to WBU over valid/ready. Sits between EXU and the data-memory model.

---
 rtl/ysyx_23060201_lsu.sv | 175 +++++++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one EXU load/store, drives the data-memory strobe port,
// extracts/extends load data and returns the result to WBU over valid/ready.
module ysyx_23060201_lsu #(
    parameter int unsigned MEM_ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_ren,
    input  logic                      in_wen,
    input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    input  logic [2:0]                in_funct3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_rdata,
    output logic                      out_err,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]                mem_rmask,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    localparam logic [2:0] CntInit = 3'(RD_LATENCY - 1);

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [2:0]                cnt_q, cnt_d;
    logic                      store_q, store_d;
    logic                      err_q, err_d;

    logic                      f3_ok;
    logic                      misaligned;
    logic [1:0]                off;
    logic [3:0]                lane_mask;
    logic [DATA_WIDTH-1:0]     lane;
    logic [DATA_WIDTH-1:0]     load_ext;
    logic [MEM_ADDR_WIDTH-1:0] word_addr;

    // Legality is judged on the incoming request; a store takes priority over ren.
    always_comb begin
        f3_ok = 1'b0;
        if (in_wen) begin
            f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
        end else begin
            f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                    (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
        end
        misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    end

    assign off       = addr_q[1:0];
    assign word_addr = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign lane      = mem_rdata >> {off, 3'b000};

    always_comb begin
        lane_mask = 4'b1111;
        case (funct3_q[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        load_ext = lane;
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    funct3_d = in_funct3;
                    store_d  = in_wen;
                    cnt_d    = CntInit;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (!in_wen && !in_ren) begin
                        state_d = StResp;
                    end else if (!f3_ok || misaligned) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq, StWait: begin
                if (store_q) begin
                    state_d = StResp;
                end else if (cnt_q == 3'd0) begin
                    // Final read cycle: capture on the edge that ends it.
                    rdata_d = load_ext;
                    state_d = StResp;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = StWait;
                end
            end
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StResp);
        out_rdata = (state_q == StResp) ? rdata_q : '0;
        out_err   = (state_q == StResp) ? err_q : 1'b0;
        mem_wen   = (state_q == StReq) && store_q;
        mem_ren   = ((state_q == StReq) || (state_q == StWait)) && !store_q;
        mem_waddr = mem_wen ? word_addr : '0;
        mem_wmask = mem_wen ? {4'b0000, lane_mask} : 8'h00;
        mem_wdata = mem_wen ? (wdata_q << {off, 3'b000}) : '0;
        mem_raddr = mem_ren ? word_addr : '0;
        mem_rmask = mem_ren ? {4'b0000, lane_mask} : 8'h00;
    end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Bench for ysyx_23060201_lsu: one RD_LATENCY=1 and one RD_LATENCY=3 instance sharing a
// word memory; expectations come from a byte-addressed reference memory and RISC-V rules.
module tb_ysyx_23060201_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ren = 1'b0;
    logic        in_wen = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [2:0]  in_funct3 = '0;
    logic        out_ready = 1'b0;

    logic        in_valid_1, in_ready_1, out_valid_1, out_err_1, mem_wen_1, mem_ren_1;
    logic [31:0] out_rdata_1, mem_waddr_1, mem_wdata_1, mem_raddr_1, mem_rdata_1;
    logic [7:0]  mem_wmask_1, mem_rmask_1;
    logic        in_valid_3, in_ready_3, out_valid_3, out_err_3, mem_wen_3, mem_ren_3;
    logic [31:0] out_rdata_3, mem_waddr_3, mem_wdata_3, mem_raddr_3, mem_rdata_3;
    logic [7:0]  mem_wmask_3, mem_rmask_3;

    logic [31:0] dev_mem [0:255];
    logic [7:0]  ref_mem [0:1023];

    int n_pass = 0;
    int n_total = 0;

    assign in_valid_1  = in_valid & ~sel;
    assign in_valid_3  = in_valid & sel;
    assign mem_rdata_1 = dev_mem[mem_raddr_1[9:2]];
    assign mem_rdata_3 = dev_mem[mem_raddr_3[9:2]];

    logic        in_ready_s, out_valid_s, out_err_s, mem_wen_s, mem_ren_s;
    logic [31:0] out_rdata_s, mem_waddr_s, mem_wdata_s, mem_raddr_s;
    logic [7:0]  mem_wmask_s, mem_rmask_s;
    assign in_ready_s  = sel ? in_ready_3  : in_ready_1;
    assign out_valid_s = sel ? out_valid_3 : out_valid_1;
    assign out_err_s   = sel ? out_err_3   : out_err_1;
    assign out_rdata_s = sel ? out_rdata_3 : out_rdata_1;
    assign mem_wen_s   = sel ? mem_wen_3   : mem_wen_1;
    assign mem_ren_s   = sel ? mem_ren_3   : mem_ren_1;
    assign mem_waddr_s = sel ? mem_waddr_3 : mem_waddr_1;
    assign mem_wdata_s = sel ? mem_wdata_3 : mem_wdata_1;
    assign mem_wmask_s = sel ? mem_wmask_3 : mem_wmask_1;
    assign mem_raddr_s = sel ? mem_raddr_3 : mem_raddr_1;
    assign mem_rmask_s = sel ? mem_rmask_3 : mem_rmask_1;

    ysyx_23060201_lsu #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_ren(in_ren), .in_wen(in_wen),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_rdata(out_rdata_1),
        .out_err(out_err_1),
        .mem_wen(mem_wen_1), .mem_waddr(mem_waddr_1), .mem_wmask(mem_wmask_1),
        .mem_wdata(mem_wdata_1), .mem_ren(mem_ren_1), .mem_raddr(mem_raddr_1),
        .mem_rmask(mem_rmask_1), .mem_rdata(mem_rdata_1)
    );

    ysyx_23060201_lsu #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_3), .in_ready(in_ready_3), .in_ren(in_ren), .in_wen(in_wen),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
        .out_valid(out_valid_3), .out_ready(out_ready), .out_rdata(out_rdata_3),
        .out_err(out_err_3),
        .mem_wen(mem_wen_3), .mem_waddr(mem_waddr_3), .mem_wmask(mem_wmask_3),
        .mem_wdata(mem_wdata_3), .mem_ren(mem_ren_3), .mem_raddr(mem_raddr_3),
        .mem_rmask(mem_rmask_3), .mem_rdata(mem_rdata_3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        dev_mem[addr[9:2]] = word;
        for (int b = 0; b < 4; b++) begin
            ref_mem[10'({addr[9:2], 2'b00} + b)] = word[8*b +: 8];
        end
    endtask

    task automatic run_txn(input logic lat3, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int stall);
        int          nbytes, off, ba, lat, ren_cyc, wen_cyc, exp_lat, exp_ren, exp_wen;
        logic        is_store, is_load, legal, exp_err;
        logic [31:0] exp_rdata, exp_wd, word_addr, val;
        logic [7:0]  exp_mask;

        is_store  = wen;
        is_load   = ren && !wen;
        off       = int'(addr[1:0]);
        ba        = int'(addr[9:0]);
        nbytes    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal     = is_store ? (f3 <= 3'd2)
                             : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        word_addr = addr & 32'hFFFF_FFFC;
        exp_rdata = '0;
        exp_wd    = '0;
        exp_mask  = '0;
        exp_err   = 1'b0;
        exp_ren   = 0;
        exp_wen   = 0;
        exp_lat   = 1;
        if (is_store || is_load) begin
            if (!legal || (off % nbytes) != 0) begin
                exp_err = 1'b1;
            end else begin
                exp_mask = 8'(((1 << nbytes) - 1) << off);
                if (is_store) begin
                    exp_lat = 2;
                    exp_wen = 1;
                    exp_wd  = wdata << (8 * off);
                    for (int i = 0; i < nbytes; i++) ref_mem[10'(ba + i)] = wdata[8*i +: 8];
                end else begin
                    exp_ren = lat3 ? 3 : 1;
                    exp_lat = exp_ren + 1;
                    val = '0;
                    for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[10'(ba + i)];
                    exp_rdata = val;
                    if (!f3[2] && nbytes == 1 && val[7])  exp_rdata = val | 32'hFFFF_FF00;
                    if (!f3[2] && nbytes == 2 && val[15]) exp_rdata = val | 32'hFFFF_0000;
                end
            end
        end

        @(negedge clk);
        sel = lat3;
        #1;
        check("in_ready idle", 32'(in_ready_s), 32'd1);
        in_valid  = 1'b1;
        in_ren    = ren;
        in_wen    = wen;
        in_addr   = addr;
        in_wdata  = wdata;
        in_funct3 = f3;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_ren    = 1'($urandom);
        in_wen    = 1'($urandom);
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_funct3 = 3'($urandom);

        lat = 0;
        ren_cyc = 0;
        wen_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_ren_s) begin
                ren_cyc++;
                check("raddr", mem_raddr_s, word_addr);
                check("rmask", 32'(mem_rmask_s), 32'(exp_mask));
            end else begin
                check("raddr idle", mem_raddr_s, 32'd0);
                check("rmask idle", 32'(mem_rmask_s), 32'd0);
            end
            if (mem_wen_s) begin
                wen_cyc++;
                check("waddr", mem_waddr_s, word_addr);
                check("wmask", 32'(mem_wmask_s), 32'(exp_mask));
                check("wdata", mem_wdata_s, exp_wd);
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask_s[b]) dev_mem[mem_waddr_s[9:2]][8*b +: 8] = mem_wdata_s[8*b +: 8];
                end
            end else begin
                check("waddr idle", mem_waddr_s, 32'd0);
                check("wmask idle", 32'(mem_wmask_s), 32'd0);
                check("wdata idle", mem_wdata_s, 32'd0);
            end
            if (out_valid_s) begin
                lat = c;
                break;
            end
            check("in_ready busy", 32'(in_ready_s), 32'd0);
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("ren cycles", 32'(ren_cyc), 32'(exp_ren));
        check("wen cycles", 32'(wen_cyc), 32'(exp_wen));
        check("out_rdata", out_rdata_s, exp_rdata);
        check("out_err", 32'(out_err_s), 32'(exp_err));
        check("in_ready resp", 32'(in_ready_s), 32'd0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall valid", 32'(out_valid_s), 32'd1);
            check("stall rdata", out_rdata_s, exp_rdata);
            check("stall err", 32'(out_err_s), 32'(exp_err));
            check("stall in_ready", 32'(in_ready_s), 32'd0);
            check("stall strobes", 32'({mem_ren_s, mem_wen_s}), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready after hs", 32'(in_ready_s), 32'd1);
        check("valid after hs", 32'(out_valid_s), 32'd0);
    endtask

    initial begin
        for (int w = 0; w < 256; w++) preload(32'h8000_0000 + 32'(w * 4), $urandom);

        // Reset state, checked while reset is held.
        #3;
        check("rst in_ready", 32'(in_ready_1), 32'd1);
        check("rst out_valid", 32'({out_valid_1, out_valid_3}), 32'd0);
        check("rst strobes", 32'({mem_ren_1, mem_wen_1, mem_ren_3, mem_wen_3}), 32'd0);
        check("rst rdata", out_rdata_1, 32'd0);
        check("rst err", 32'(out_err_1), 32'd0);
        check("rst waddr", mem_waddr_1, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_txn(1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 0);
        run_txn(1'b0, 1'b0, 1'b1, 32'h8000_0003, 32'h0000_00A5, 3'b000, 0);
        run_txn(1'b0, 1'b0, 1'b1, 32'h8000_0002, 32'h0000_1234, 3'b001, 1);

        preload(32'h8000_0000, 32'h12F4_5678);
        run_txn(1'b0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b000, 0);
        check("LB value", out_rdata_s, 32'h0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b100, 0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b001, 2);
        run_txn(1'b0, 1'b1, 1'b0, 32'h8000_0001, 32'h0, 3'b010, 0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'b011, 0);
        run_txn(1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h5555_5555, 3'b010, 0);
        run_txn(1'b0, 1'b1, 1'b1, 32'h8000_0008, 32'h0BAD_CAFE, 3'b010, 0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 3'b010, 0);

        preload(32'h8000_0010, 32'h8765_4321);
        run_txn(1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 3);

        // Reset during a RD_LATENCY=3 load in WAIT.
        @(negedge clk);
        sel = 1'b1;
        in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0;
        in_addr = 32'h8000_0010; in_funct3 = 3'b010;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ren before rst", 32'(mem_ren_3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ren async drop", 32'(mem_ren_3), 32'd0);
        check("raddr async drop", mem_raddr_3, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("no resp after rst", 32'({out_valid_3, mem_ren_3}), 32'd0);
        end

        // Reset during a store REQ: the write must never reach memory.
        preload(32'h8000_0020, 32'h1357_9BDF);
        @(negedge clk);
        sel = 1'b0;
        in_valid = 1'b1; in_ren = 1'b0; in_wen = 1'b1;
        in_addr = 32'h8000_0020; in_wdata = 32'hCAFE_F00D; in_funct3 = 3'b010;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("wen before rst", 32'(mem_wen_1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("wen async drop", 32'(mem_wen_1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("no store resp", 32'({out_valid_1, mem_wen_1}), 32'd0);
        end
        run_txn(1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 3'b010, 0);
        run_txn(1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 0);

        for (int t = 0; t < 80; t++) begin
            run_txn(1'($urandom), 1'($urandom), 1'($urandom),
                    32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom,
                    3'($urandom), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
